// File: rtl/uart_rx_oversampled_pkg.sv
// Shared definitions for the oversampled 8N1 UART receiver: FSM states, frame
// width and the tick-divider calculation.
package uart_rx_oversampled_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_WAIT  = 3'd4
  } rx_state_e;

  // Clocks per sample tick; never below one so the divider always runs.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_tick.sv
// Free-running divider producing one sample tick every DIV clocks
// (OVERSAMPLE ticks per serial bit).
module oversample_tick
  import uart_rx_oversampled_pkg::*;
#(
  parameter int baudRate       = 100,
  parameter int clockFrequency = 50000000,
  parameter int OVERSAMPLE     = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(clockFrequency, baudRate, OVERSAMPLE);
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == DIV_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling at OVERSAMPLE x baud,
// registered rxValid / frameError pulses one clock after the mid-stop sample.
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int baudRate       = 100,
  parameter int clockFrequency = 50000000,
  parameter int OVERSAMPLE     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxSerialIn,
  output logic [7:0] rxDataOut,
  output logic       rxValid,
  output logic       frameError,
  output logic       rxBusy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_HALF = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  logic                 tick;
  logic                 sync1_q, sync2_q, rxs;
  rx_state_e            state_q, state_d;
  logic [SCW-1:0]       sc_q, sc_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d;
  logic                 at_half, at_last;

  oversample_tick #(
    .baudRate      (baudRate),
    .clockFrequency(clockFrequency),
    .OVERSAMPLE    (OVERSAMPLE)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Synchronizer presets to the idle-high line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxSerialIn;
      sync2_q <= sync1_q;
    end
  end

  assign rxs     = sync2_q;
  assign at_half = tick && (sc_q == SC_HALF);
  assign at_last = tick && (sc_q == SC_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_IDLE:  if (!rxs) state_d = ST_START;
        ST_START: if (at_half) state_d = rxs ? ST_IDLE : ST_DATA;
        ST_DATA:  if (at_last && (bit_q == BIT_LAST)) state_d = ST_STOP;
        ST_STOP:  if (at_last) state_d = rxs ? ST_IDLE : ST_WAIT;
        ST_WAIT:  if (rxs) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sc_d    = sc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sc_d  = '0;
        bit_d = '0;
      end
      ST_START: begin
        if (tick) sc_d = at_half ? '0 : sc_q + SCW'(1);
      end
      ST_DATA: begin
        if (at_last) begin
          sc_d           = '0;
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 3'd1;
        end else if (tick) begin
          sc_d = sc_q + SCW'(1);
        end
      end
      ST_STOP: begin
        if (at_last) begin
          sc_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else if (tick) begin
          sc_d = sc_q + SCW'(1);
        end
      end
      default: ;
    endcase
  end

  assign rxDataOut  = data_q;
  assign rxValid    = valid_q;
  assign frameError = ferr_q;
  assign rxBusy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: frame-level reference model of expected pulses and
// held data, with directed and randomized serial frames on two divider settings.
module tb_uart_rx_oversampled;

  typedef struct {
    bit         ferr;
    logic [7:0] dat;
    int         at;
  } evt_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int both_cnt = 0;
  evt_t obs_q[$];
  evt_t exp_q[$];
  evt_t obs_b_q[$];
  logic [7:0] model_data;

  always #5 clock = ~clock;

  uart_rx_oversampled #(.baudRate(100), .clockFrequency(1600), .OVERSAMPLE(16)) u_dut_a (
    .clock(clock), .reset(reset), .rxSerialIn(rx_a), .rxDataOut(data_a),
    .rxValid(valid_a), .frameError(ferr_a), .rxBusy(busy_a)
  );

  uart_rx_oversampled #(.baudRate(100), .clockFrequency(16000), .OVERSAMPLE(16)) u_dut_b (
    .clock(clock), .reset(reset), .rxSerialIn(rx_b), .rxDataOut(data_b),
    .rxValid(valid_b), .frameError(ferr_b), .rxBusy(busy_b)
  );

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    evt_t e;
    e.at = cyc;
    if (valid_a) begin e.ferr = 1'b0; e.dat = data_a; obs_q.push_back(e); end
    if (ferr_a)  begin e.ferr = 1'b1; e.dat = data_a; obs_q.push_back(e); end
    if (valid_a && ferr_a) both_cnt++;
    if (valid_b) begin e.ferr = 1'b0; e.dat = data_b; obs_b_q.push_back(e); end
    if (ferr_b)  begin e.ferr = 1'b1; e.dat = data_b; obs_b_q.push_back(e); end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one line level for n clocks; every drive lands 1ns after a rising edge.
  task automatic hold_line(input bit on_b, input logic lvl, input int n);
    if (on_b) rx_b = lvl; else rx_a = lvl;
    repeat (n) @(posedge clock);
    if (n > 0) #1;
  endtask

  // Bad-stop frames leave the line low; the caller decides when it returns high.
  task automatic send_frame(input bit on_b, input logic [7:0] d, input bit stop_ok,
                            input int low_extra, output int t_start);
    int bc;
    bc = on_b ? 160 : 16;
    t_start = cyc;
    hold_line(on_b, 1'b0, bc);
    for (int i = 0; i < 8; i++) hold_line(on_b, d[i], bc);
    if (stop_ok) hold_line(on_b, 1'b1, bc);
    else         hold_line(on_b, 1'b0, bc + low_extra);
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit stop_ok);
    evt_t e;
    e.at = 0;
    if (stop_ok) begin
      e.ferr = 1'b0; e.dat = d; model_data = d;
    end else begin
      e.ferr = 1'b1; e.dat = model_data;
    end
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    int n;
    check_eq({tag, "_nevt"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_kind"}, {31'd0, obs_q[i].ferr}, {31'd0, exp_q[i].ferr});
      check_eq({tag, "_dat"}, {24'd0, obs_q[i].dat}, {24'd0, exp_q[i].dat});
    end
    check_eq({tag, "_held"}, {24'd0, data_a}, {24'd0, model_data});
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0, t1, lat, fell_at;
    bit saw_busy;
    logic [7:0] d;
    bit ok;

    reset = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    model_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_data", {24'd0, data_a}, 32'h0);
    check_eq("rst_valid", {31'd0, valid_a}, 32'h0);
    check_eq("rst_ferr", {31'd0, ferr_a}, 32'h0);
    check_eq("rst_busy", {31'd0, busy_a}, 32'h0);
    reset = 1'b1;
    hold_line(1'b0, 1'b1, 20);

    // Single frame and fixed start-edge-to-pulse latency (3 + 152 clocks at DIV=1).
    send_frame(1'b0, 8'hA5, 1'b1, 0, t0);
    expect_frame(8'hA5, 1'b1);
    lat = (obs_q.size() > 0) ? obs_q[0].at - t0 : -1;
    check_eq("t1_latency", lat, 155);
    check_eq("t1_busy_after", {31'd0, busy_a}, 32'h0);
    compare_events("t1");

    // Back-to-back frames with a single stop bit.
    send_frame(1'b0, 8'h00, 1'b1, 0, t0);
    send_frame(1'b0, 8'hFF, 1'b1, 0, t1);
    expect_frame(8'h00, 1'b1);
    expect_frame(8'hFF, 1'b1);
    hold_line(1'b0, 1'b1, 4);
    lat = (obs_q.size() >= 2) ? obs_q[1].at - obs_q[0].at : -1;
    check_eq("t2_spacing", lat, 160);
    compare_events("t2");

    // Start-bit glitch: accepted then rejected at mid-start, no pulses.
    t0 = cyc;
    saw_busy = 1'b0;
    fell_at = -1;
    hold_line(1'b0, 1'b0, 4);
    rx_a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (busy_a) saw_busy = 1'b1;
      if (saw_busy && !busy_a && fell_at < 0) fell_at = cyc - t0;
    end
    @(posedge clock);
    #1;
    check_eq("t3_busy_rose", {31'd0, saw_busy}, 32'h1);
    check_eq("t3_busy_fell_by_12", {31'd0, (fell_at >= 0 && fell_at <= 12)}, 32'h1);
    compare_events("t3");

    // Framing error with a stuck-low line, then recovery.
    send_frame(1'b0, 8'h3C, 1'b0, 40, t0);
    expect_frame(8'h3C, 1'b0);
    check_eq("t4_busy_while_low", {31'd0, busy_a}, 32'h1);
    compare_events("t4");
    hold_line(1'b0, 1'b1, 5);
    check_eq("t4_busy_released", {31'd0, busy_a}, 32'h0);
    send_frame(1'b0, 8'h81, 1'b1, 0, t0);
    expect_frame(8'h81, 1'b1);
    compare_events("t4_next");

    // Randomized frames, stop bits and idle gaps.
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(1'b0, d, ok, $urandom_range(0, 40), t0);
      expect_frame(d, ok);
      if (ok) hold_line(1'b0, 1'b1, $urandom_range(0, 12));
      else    hold_line(1'b0, 1'b1, $urandom_range(1, 10));
      compare_events("rand");
    end

    // Reset in the middle of data bit 4 aborts the frame and clears the byte.
    send_frame(1'b0, 8'hE7, 1'b1, 0, t0);
    expect_frame(8'hE7, 1'b1);
    compare_events("t5_pre");
    d = 8'h55;
    hold_line(1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) hold_line(1'b0, d[i], 16);
    hold_line(1'b0, d[4], 8);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_data", {24'd0, data_a}, 32'h0);
    check_eq("t5_rst_valid", {31'd0, valid_a}, 32'h0);
    check_eq("t5_rst_ferr", {31'd0, ferr_a}, 32'h0);
    check_eq("t5_rst_busy", {31'd0, busy_a}, 32'h0);
    model_data = 8'h00;
    rx_a = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    hold_line(1'b0, 1'b1, 20);
    compare_events("t5_abort");
    send_frame(1'b0, 8'h55, 1'b1, 0, t0);
    expect_frame(8'h55, 1'b1);
    compare_events("t5_after");

    // Slower divider (DIV=10): latency within 9.5 bits +/- 1 tick of the edge.
    hold_line(1'b1, 1'b1, $urandom_range(0, 9));
    send_frame(1'b1, 8'hC3, 1'b1, 0, t0);
    check_eq("t6_nevt", obs_b_q.size(), 1);
    lat = (obs_b_q.size() > 0) ? obs_b_q[0].at - t0 : -1;
    check_eq("t6_latency_window", {31'd0, (lat >= 1513 && lat <= 1533)}, 32'h1);
    check_eq("t6_data", {24'd0, data_b}, 32'h0000_00C3);
    check_eq("t6_kind", {31'd0, (obs_b_q.size() > 0) ? obs_b_q[0].ferr : 1'b1}, 32'h0);

    check_eq("never_both_pulses", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
